// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Operation encodings and the sequencer state type.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Shared sequential engine for MULT/MULTU/DIV/DIVU.
// One result bit per cycle on magnitudes, sign fixed up at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             ready,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] f_mag(
    input logic [WIDTH-1:0] x,
    input logic             sgn
  );
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]    r_count;
  logic             r_is_div;
  logic             r_divz;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_ph;
  logic [WIDTH-1:0] r_pl;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_ready;
  logic             r_dz;

  logic             w_signed;
  logic             w_is_div;
  logic             w_divz;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_ph_nxt;
  logic [WIDTH-1:0] w_pl_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign w_divz   = w_is_div && (b == '0);
  assign w_abs_a  = f_mag(a, w_signed);
  assign w_abs_b  = f_mag(b, w_signed);

  assign w_msum  = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_a} : '0);
  assign w_shift = {r_ph, r_pl[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_b};
  assign w_diff  = w_shift[WIDTH-1:0] - r_b;

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    w_ph_nxt = w_msum[WIDTH:1];
    w_pl_nxt = {w_msum[0], r_pl[WIDTH-1:1]};
    if (r_is_div) begin
      w_ph_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_pl_nxt = {r_pl[WIDTH-2:0], w_ge};
    end
  end

  // Sign correction of the magnitude result.
  always_comb begin
    w_prod   = r_neg_q ? -{r_ph, r_pl} : {r_ph, r_pl};
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_hi = r_neg_r ? -r_ph : r_ph;
      w_fix_lo = r_neg_q ? -r_pl : r_pl;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = w_divz ? FIX : RUN;
      RUN:  if (r_count == LAST) w_state_nxt = FIX;
      FIX:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_divz   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_ph     <= '0;
      r_pl     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_ready  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_is_div <= w_is_div;
            r_divz   <= w_divz;
            r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= w_signed && a[WIDTH-1];
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            r_ph     <= '0;
            r_pl     <= w_is_div ? w_abs_a : w_abs_b;
            r_count  <= '0;
            r_dz     <= 1'b0;
          end
        end
        RUN: begin
          r_ph    <= w_ph_nxt;
          r_pl    <= w_pl_nxt;
          r_count <= r_count + CW'(1);
        end
        FIX: begin
          r_ready <= 1'b1;
          if (r_divz) begin
            r_dz <= 1'b1;
          end else begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign ready    = r_ready;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32.
// Reference results come from plain integer * / and %.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo;
  logic         busy, ready, div_zero;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy),
    .ready(ready), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t e;
    longint p, q, r;
    logic [63:0] u;
    e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0; e.due = 0;
    case (o)
      OP_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      OP_MULTU: begin
        u = {32'b0, x} * {32'b0, y};
        e.hi = u[63:32]; e.lo = u[31:0];
      end
      OP_DIV: begin
        if (y == 0) e.dz = 1'b1;
        else begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          e.lo = q[31:0]; e.hi = r[31:0];
        end
      end
      default: begin
        if (y == 0) e.dz = 1'b1;
        else begin
          e.lo = x / y; e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ready === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_zero", div_zero, e.dz);
        chk("latency", cyc, e.due);
      end
    end
  end

  task automatic issue_now(input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    e = model(o, x, y);
    @(posedge clk);
    #1;
    start = 1'b0;
    e.due = cyc + (e.dz ? 1 : W + 1);
    m_hi = e.hi; m_lo = e.lo;
    sbq.push_back(e);
    chk("busy_on_accept", busy, 1'b1);
    chk("dz_clear_on_start", div_zero, 1'b0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    issue_now(o, x, y);
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() > 0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("drain", sbq.size(), 0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    chk("hold_hi", hi, m_hi);
    chk("hold_lo", lo, m_lo);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic dir(input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] ehi,
                     input logic [31:0] elo, input logic edz);
    issue(o, x, y);
    drain();
    chk("plan_hi", hi, ehi);
    chk("plan_lo", lo, elo);
    chk("plan_dz", div_zero, edz);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h7FFF_FFFF;
      3: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_dz", div_zero, 1'b0);
    reset = 1'b0;

    dir(OP_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    dir(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 32'h0000_0001, 0);
    dir(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 0);
    dir(OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    dir(OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 0);
    dir(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
    dir(OP_DIVU,  32'd47, 32'd7, 32'd5, 32'd6, 0);
    dir(OP_DIVU,  32'd9, 32'd0, 32'd5, 32'd6, 1);
    dir(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0);

    // Reset ten edges into a multiply discards it.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd1234; b = 32'd5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_ready", ready, 1'b0);
    repeat (40) @(posedge clk);

    // Start while busy is ignored.
    issue(OP_MULTU, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd77; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(posedge clk);

    // Start in the ready cycle is taken without a gap.
    issue(OP_DIV, 32'hFFFF_FF00, 32'd7);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ready !== 1'b1 && k < 100);
    chk("b2b_ready_seen", ready, 1'b1);
    issue_now(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      if (o[1] && $urandom_range(0, 7) == 0) y = 32'h0;
      issue(o, x, y);
      drain();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
